// File: rtl/cmd_dec_pkg.sv
// Shared state encoding and default protocol constants for the uplink command decoder.
package cmd_dec_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        CFG,
        CMOS,
        DRAIN
    } state_t;

    localparam logic [31:0] DEF_HEAD_PATTERN = 32'h7CD2_15D8;
    localparam logic [7:0]  DEF_OP_CFG       = 8'hA;
    localparam logic [7:0]  DEF_OP_CMOS      = 8'h55;
    localparam logic [7:0]  DEF_OP_FPGA      = 8'hFF;

endpackage

// File: rtl/cd_header_match.sv
// Sync header detector: a window of the last HEAD_WORDS valid words, cleared by any
// receive_en gap, with a registered match flag.
module cd_header_match #(
    parameter int DATA_W = 16,
    parameter int HEAD_WORDS = 2,
    parameter logic [HEAD_WORDS*DATA_W-1:0] HEAD_PATTERN = '0
) (
    input  logic              clk_input,
    input  logic              reset,
    input  logic              receive_en,
    input  logic [DATA_W-1:0] data_in,
    output logic              match
);

    localparam int CNT_W = $clog2(HEAD_WORDS + 1);
    localparam logic [CNT_W-1:0] FULL_RUN = CNT_W'(HEAD_WORDS);

    logic [HEAD_WORDS*DATA_W-1:0]     window;
    logic [(HEAD_WORDS+1)*DATA_W-1:0] shifted;
    logic [HEAD_WORDS*DATA_W-1:0]     window_next;
    logic [CNT_W-1:0]                 run;
    logic [CNT_W-1:0]                 run_next;

    // Newest word enters at the LS end, so the first header word ends up in the MS word.
    assign shifted     = {window, data_in};
    assign window_next = shifted[HEAD_WORDS*DATA_W-1:0];
    assign run_next    = (run == FULL_RUN) ? run : run + 1'b1;

    always_ff @(posedge clk_input) begin
        if (reset || !receive_en) begin
            window <= '0;
            run    <= '0;
            match  <= 1'b0;
        end else begin
            window <= window_next;
            run    <= run_next;
            match  <= (run_next == FULL_RUN) && (window_next == HEAD_PATTERN);
        end
    end

endmodule

// File: rtl/command_decoder_mc.sv
// Uplink command decoder: finds the sync header, decodes one command word and routes
// the payload to the CMOS FIFO, a config RAM region or the FPGA command register.
module command_decoder_mc
    import cmd_dec_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int HEAD_WORDS = 2,
    parameter logic [HEAD_WORDS*DATA_W-1:0] HEAD_PATTERN = DEF_HEAD_PATTERN,
    parameter int OFS_W = 8,
    parameter int REG_W = 2,
    parameter logic [7:0] OP_CFG = DEF_OP_CFG,
    parameter logic [7:0] OP_CMOS = DEF_OP_CMOS,
    parameter logic [7:0] OP_FPGA = DEF_OP_FPGA
) (
    input  logic                   clk_input,
    input  logic                   reset,
    input  logic                   receive_en,
    input  logic [DATA_W-1:0]      data_in,
    output logic [DATA_W-1:0]      data_out,
    output logic                   fifo_cmos_en,
    output logic                   config_ram_en,
    output logic [REG_W+OFS_W-1:0] config_ram_addr,
    output logic [7:0]             FPGA_command,
    output logic                   FPGA_command_latch,
    output logic                   frame_err,
    output logic                   addr_overflow
);

    state_t state, state_n;

    logic              match;
    logic [DATA_W-1:0] d_r;
    logic              en_r, en_d;
    logic [REG_W-1:0]  region, region_n;
    logic [7:0]        len, len_n;
    logic [7:0]        cnt, cnt_n;
    logic [OFS_W-1:0]  ofs, ofs_n;
    logic              full, full_n;

    logic [DATA_W-1:0]      data_n;
    logic                   cmos_n, ram_n, latch_n, err_n, ovf_n;
    logic [REG_W+OFS_W-1:0] addr_n;
    logic [7:0]             fpga_n;

    // The detector looks at the raw stream so its match lines up with the command word
    // arriving in d_r on the first CMD cycle.
    cd_header_match #(
        .DATA_W      (DATA_W),
        .HEAD_WORDS  (HEAD_WORDS),
        .HEAD_PATTERN(HEAD_PATTERN)
    ) u_header_match (
        .clk_input (clk_input),
        .reset     (reset),
        .receive_en(receive_en),
        .data_in   (data_in),
        .match     (match)
    );

    always_comb begin
        // NOTE: every variable gets a default before the case so no path can infer a latch.
        state_n  = state;
        region_n = region;
        len_n    = len;
        cnt_n    = cnt;
        ofs_n    = ofs;
        full_n   = full;
        data_n   = data_out;
        addr_n   = config_ram_addr;
        fpga_n   = FPGA_command;
        cmos_n   = 1'b0;
        ram_n    = 1'b0;
        latch_n  = 1'b0;
        err_n    = 1'b0;
        ovf_n    = 1'b0;

        unique case (state)
            IDLE: if (match) state_n = CMD;
            CMD: begin
                if (en_r) begin
                    if (d_r[DATA_W-1 -: 4] == OP_CFG[3:0]) begin
                        state_n  = CFG;
                        region_n = d_r[DATA_W-5 -: REG_W];
                        len_n    = d_r[7:0];
                        cnt_n    = '0;
                        ofs_n    = '0;
                        full_n   = 1'b0;
                    end else if (d_r[DATA_W-1 -: 8] == OP_CMOS) begin
                        state_n = CMOS;
                    end else if (d_r[DATA_W-1 -: 8] == OP_FPGA) begin
                        fpga_n  = d_r[7:0];
                        latch_n = 1'b1;
                        state_n = DRAIN;
                    end else begin
                        err_n   = 1'b1;
                        state_n = DRAIN;
                    end
                end else if (!en_d) begin
                    err_n   = 1'b1;
                    state_n = IDLE;
                end
            end
            CFG: begin
                if (en_r) begin
                    if (full) begin
                        ovf_n   = 1'b1;
                        state_n = DRAIN;
                    end else begin
                        ram_n  = 1'b1;
                        data_n = d_r;
                        addr_n = {region, ofs};
                        cnt_n  = cnt + 8'd1;
                        // The last offset is written, then the region is marked full instead of wrapping.
                        if (&ofs) full_n = 1'b1;
                        else      ofs_n  = ofs + OFS_W'(1);
                        if (len != 8'd0 && cnt + 8'd1 == len) state_n = DRAIN;
                    end
                end else if (!en_d) begin
                    state_n = IDLE;
                end
            end
            CMOS: begin
                if (en_r) begin
                    cmos_n = 1'b1;
                    data_n = d_r;
                end else if (!en_d) begin
                    state_n = IDLE;
                end
            end
            DRAIN: if (!en_r) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_input) begin
        if (reset) begin
            state              <= IDLE;
            d_r                <= '0;
            en_r               <= 1'b0;
            en_d               <= 1'b0;
            region             <= '0;
            len                <= '0;
            cnt                <= '0;
            ofs                <= '0;
            full               <= 1'b0;
            data_out           <= '0;
            fifo_cmos_en       <= 1'b0;
            config_ram_en      <= 1'b0;
            config_ram_addr    <= '0;
            FPGA_command       <= '0;
            FPGA_command_latch <= 1'b0;
            frame_err          <= 1'b0;
            addr_overflow      <= 1'b0;
        end else begin
            // NOTE: non-blocking updates keep every register sampling pre-edge values.
            state              <= state_n;
            d_r                <= data_in;
            en_r               <= receive_en;
            en_d               <= en_r;
            region             <= region_n;
            len                <= len_n;
            cnt                <= cnt_n;
            ofs                <= ofs_n;
            full               <= full_n;
            data_out           <= data_n;
            fifo_cmos_en       <= cmos_n;
            config_ram_en      <= ram_n;
            config_ram_addr    <= addr_n;
            FPGA_command       <= fpga_n;
            FPGA_command_latch <= latch_n;
            frame_err          <= err_n;
            addr_overflow      <= ovf_n;
        end
    end

endmodule

// File: tb/tb_command_decoder_mc.sv
// Self-checking bench for command_decoder_mc: directed frames plus random frames, each
// turned into an expected event list (kind, data, address, output cycle).
module tb_command_decoder_mc;

    localparam int DW = 16;

    logic          clk_input = 1'b0;
    logic          reset = 1'b1;
    logic          receive_en = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [DW-1:0] data_out;
    logic          fifo_cmos_en, config_ram_en, FPGA_command_latch, frame_err, addr_overflow;
    logic [9:0]    config_ram_addr;
    logic [7:0]    FPGA_command;

    command_decoder_mc dut (
        .clk_input         (clk_input),
        .reset             (reset),
        .receive_en        (receive_en),
        .data_in           (data_in),
        .data_out          (data_out),
        .fifo_cmos_en      (fifo_cmos_en),
        .config_ram_en     (config_ram_en),
        .config_ram_addr   (config_ram_addr),
        .FPGA_command      (FPGA_command),
        .FPGA_command_latch(FPGA_command_latch),
        .frame_err         (frame_err),
        .addr_overflow     (addr_overflow)
    );

    always #5 clk_input = ~clk_input;

    localparam logic [2:0] EV_CFG = 3'd1, EV_FIFO = 3'd2, EV_FPGA = 3'd3, EV_ERR = 3'd4, EV_OVF = 3'd5;

    typedef struct packed {
        logic [2:0]  kind;
        logic [15:0] data;
        logic [9:0]  addr;
        logic [31:0] cyc;
    } ev_t;

    ev_t         exp_q[$];
    logic [15:0] pay_q[$];
    int          cyc = 0;
    int          last_cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;
    bit          mon_en = 1'b0;
    logic [7:0]  fpga_model = 8'h00;

    always @(posedge clk_input) cyc <= cyc + 1;

    task automatic drive(input logic en, input logic [15:0] d);
        @(posedge clk_input);
        #1;
        receive_en = en;
        data_in    = d;
        last_cyc   = cyc;
    endtask

    task automatic expect_ev(input logic [2:0] k, input logic [15:0] d, input logic [9:0] a, input int c);
        ev_t e;
        e.kind = k;
        e.data = d;
        e.addr = a;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 16'($urandom));
    endtask

    task automatic header();
        drive(1'b1, 16'h7CD2);
        drive(1'b1, 16'h15D8);
    endtask

    task automatic fill_seq(input logic [15:0] base, input int n);
        pay_q.delete();
        for (int i = 0; i < n; i++) pay_q.push_back(base + 16'(i));
    endtask

    task automatic fill_random(input int n);
        pay_q.delete();
        for (int i = 0; i < n; i++) pay_q.push_back(16'($urandom));
    endtask

    // Every payload word reaches the outputs two cycles after it is presented.
    task automatic frame_cmos(input logic [7:0] lo, input bit gaps);
        logic [15:0] w;
        header();
        drive(1'b1, {8'h55, lo});
        for (int i = 0; i < pay_q.size(); i++) begin
            if (gaps && $urandom_range(0, 3) == 0) drive(1'b0, 16'($urandom));
            w = pay_q[i];
            drive(1'b1, w);
            expect_ev(EV_FIFO, w, '0, last_cyc + 2);
        end
        idle(3);
    endtask

    task automatic frame_cfg(input logic [15:0] cmd, input bit gaps);
        logic [1:0]  region;
        logic [7:0]  len;
        logic [15:0] w;
        bit          done;
        region = cmd[11:10];
        len    = cmd[7:0];
        done   = 1'b0;
        header();
        drive(1'b1, cmd);
        for (int i = 0; i < pay_q.size(); i++) begin
            if (gaps && $urandom_range(0, 3) == 0) drive(1'b0, 16'($urandom));
            w = pay_q[i];
            drive(1'b1, w);
            if (!done) begin
                if (len != 8'd0 && i >= int'(len)) begin
                    done = 1'b1;
                end else if (i >= 256) begin
                    expect_ev(EV_OVF, '0, '0, last_cyc + 2);
                    done = 1'b1;
                end else begin
                    expect_ev(EV_CFG, w, {region, 8'(i)}, last_cyc + 2);
                end
            end
        end
        idle(3);
    endtask

    task automatic frame_fpga(input logic [7:0] b, input int ntrail);
        header();
        drive(1'b1, {8'hFF, b});
        expect_ev(EV_FPGA, {8'h00, b}, '0, last_cyc + 2);
        fpga_model = b;
        for (int i = 0; i < ntrail; i++) drive(1'b1, 16'($urandom));
        idle(3);
    endtask

    task automatic frame_bad(input logic [15:0] cmd, input int ntrail);
        header();
        drive(1'b1, cmd);
        expect_ev(EV_ERR, '0, '0, last_cyc + 2);
        for (int i = 0; i < ntrail; i++) drive(1'b1, 16'($urandom));
        idle(3);
    endtask

    // Header with no command word: the second idle cycle ends the frame with an error.
    task automatic frame_trunc();
        header();
        drive(1'b0, 16'($urandom));
        expect_ev(EV_ERR, '0, '0, last_cyc + 3);
        idle(2);
    endtask

    task automatic observe(input logic [2:0] k);
        ev_t obs, e;
        obs.kind = k;
        obs.cyc  = cyc;
        obs.data = '0;
        obs.addr = '0;
        if (k == EV_CFG || k == EV_FIFO) obs.data = data_out;
        if (k == EV_FPGA) obs.data = {8'h00, FPGA_command};
        if (k == EV_CFG) obs.addr = config_ram_addr;
        e = '0;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        vectors++;
        assert (obs === e) else begin
            miscompares++;
            $error("FAIL event: observed kind=%0d data=%h addr=%h cyc=%0d, expected kind=%0d data=%h addr=%h cyc=%0d",
                   obs.kind, obs.data, obs.addr, obs.cyc, e.kind, e.data, e.addr, e.cyc);
        end
    endtask

    always @(negedge clk_input) begin
        if (mon_en) begin
            if (config_ram_en === 1'b1)      observe(EV_CFG);
            if (fifo_cmos_en === 1'b1)       observe(EV_FIFO);
            if (FPGA_command_latch === 1'b1) observe(EV_FPGA);
            if (frame_err === 1'b1)          observe(EV_ERR);
            if (addr_overflow === 1'b1)      observe(EV_OVF);
        end
    end

    task automatic check_zero(input string tag);
        logic [38:0] outs;
        outs = {data_out, fifo_cmos_en, config_ram_en, config_ram_addr, FPGA_command,
                FPGA_command_latch, frame_err, addr_overflow};
        vectors++;
        assert (outs === 39'd0) else begin
            miscompares++;
            $error("FAIL %s: outputs observed %h, expected 0", tag, outs);
        end
    endtask

    initial begin
        logic [7:0] op;
        int         kind;

        repeat (3) @(posedge clk_input);
        #1;
        reset = 1'b0;
        check_zero("reset_state");
        mon_en = 1'b1;
        idle(2);

        fill_seq(16'h0001, 3);
        frame_cmos(8'h00, 1'b0);

        pay_q = '{16'h1111, 16'h2222, 16'h3333};
        frame_cfg(16'hA902, 1'b0);

        fill_seq(16'h0000, 257);
        frame_cfg(16'hAC00, 1'b0);

        frame_fpga(8'h3C, 2);
        frame_bad(16'h1234, 3);
        frame_trunc();

        // Split header followed by what would be a CMOS frame: nothing may come out.
        drive(1'b1, 16'h7CD2);
        drive(1'b0, 16'h0000);
        drive(1'b1, 16'h15D8);
        drive(1'b1, 16'h5500);
        drive(1'b1, 16'h0001);
        drive(1'b1, 16'h0002);
        idle(3);

        // Reset mid-CFG: only words presented at least two cycles before reset is sampled land.
        header();
        drive(1'b1, 16'hA400);
        drive(1'b1, 16'hC001);
        expect_ev(EV_CFG, 16'hC001, 10'h100, last_cyc + 2);
        drive(1'b1, 16'hC002);
        expect_ev(EV_CFG, 16'hC002, 10'h101, last_cyc + 2);
        drive(1'b1, 16'hC003);
        @(posedge clk_input);
        #1;
        reset   = 1'b1;
        data_in = 16'hC004;
        @(posedge clk_input);
        #1;
        reset   = 1'b0;
        check_zero("reset_mid_cfg");
        fpga_model = 8'h00;
        data_in = 16'hC005;
        drive(1'b1, 16'hC006);
        drive(1'b1, 16'hC007);
        idle(3);

        for (int f = 0; f < 24; f++) begin
            kind = int'($urandom_range(0, 4));
            case (kind)
                0: begin
                    fill_random(int'($urandom_range(1, 20)));
                    frame_cmos(8'($urandom), 1'b1);
                end
                1: begin
                    fill_random(int'($urandom_range(1, 30)));
                    frame_cfg({4'hA, 2'($urandom), 2'($urandom),
                               ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(1, 20))}, 1'b1);
                end
                2: frame_fpga(8'($urandom), int'($urandom_range(0, 3)));
                3: begin
                    op = 8'($urandom);
                    while (op[7:4] == 4'hA || op == 8'h55 || op == 8'hFF) op = 8'($urandom);
                    frame_bad({op, 8'($urandom)}, int'($urandom_range(0, 3)));
                end
                default: frame_trunc();
            endcase
        end

        idle(4);
        vectors++;
        assert (exp_q.size() === 0) else begin
            miscompares++;
            $error("FAIL pending_events: observed %0d still expected, expected 0", exp_q.size());
        end
        vectors++;
        assert (FPGA_command === fpga_model) else begin
            miscompares++;
            $error("FAIL fpga_hold: observed %h, expected %h", FPGA_command, fpga_model);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
